// File: rtl/sd_async_fifo.sv
// Dual-clock FWFT FIFO for the SD data path: Gray pointers cross via SYNC_STG-flop synchronisers,
// per-domain fill levels, almost flags and sticky overflow/underflow.
module sd_async_fifo #(
    parameter int unsigned DW        = 4,
    parameter int unsigned AW        = 6,
    parameter int unsigned AFULL_TH  = 60,
    parameter int unsigned AEMPTY_TH = 4,
    parameter int unsigned SYNC_STG  = 2
) (
    input  logic          wclk,
    input  logic          rst,
    input  logic          rclk,
    input  logic [DW-1:0] d,
    input  logic          wr,
    output logic          full,
    output logic          almost_full,
    output logic [AW:0]   wlevel,
    output logic          overflow,
    output logic [DW-1:0] q,
    input  logic          rd,
    output logic          empty,
    output logic          almost_empty,
    output logic [AW:0]   rlevel,
    output logic          underflow
);

    localparam int unsigned Depth    = 2 ** AW;
    localparam logic [AW:0] PtrOne   = (AW + 1)'(1);
    localparam logic [AW:0] AfullTh  = (AW + 1)'(AFULL_TH);
    localparam logic [AW:0] AemptyTh = (AW + 1)'(AEMPTY_TH);

    function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
        logic [AW:0] b;
        b = g;
        for (int i = 1; i <= int'(AW); i++) b = b ^ (g >> i);
        return b;
    endfunction

    logic [DW-1:0] mem_q [Depth];

    // ---------------- write domain ----------------
    logic [AW:0] wptr_q, wptr_d, wgray_q, wgray_d, rgray_s;
    logic [AW:0] rsync_q [SYNC_STG];
    logic        full_q, full_d, overflow_q, overflow_d, wen;
    logic [AW:0] rptr_q, rptr_d, rgray_q, rgray_d, wgray_s;
    logic [AW:0] wsync_q [SYNC_STG];
    logic        empty_q, empty_d, underflow_q, underflow_d, ren;

    assign rgray_s = rsync_q[SYNC_STG-1];

    always_comb begin
        wen        = wr & ~full_q;
        wptr_d     = wen ? wptr_q + PtrOne : wptr_q;
        wgray_d    = bin2gray(wptr_d);
        // Full when the write pointer has lapped the read pointer exactly once.
        full_d     = (wgray_d == {~rgray_s[AW:AW-1], rgray_s[AW-2:0]});
        overflow_d = overflow_q | (wr & full_q);
    end

    always_ff @(posedge wclk or posedge rst) begin
        if (rst) begin
            wptr_q     <= '0;
            wgray_q    <= '0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
            for (int i = 0; i < int'(SYNC_STG); i++) rsync_q[i] <= '0;
        end else begin
            wptr_q     <= wptr_d;
            wgray_q    <= wgray_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
            rsync_q[0] <= rgray_q;
            for (int i = 1; i < int'(SYNC_STG); i++) rsync_q[i] <= rsync_q[i-1];
        end
    end

    always_ff @(posedge wclk) begin
        if (wen) mem_q[wptr_q[AW-1:0]] <= d;
    end

    assign wlevel      = wptr_q - gray2bin(rgray_s);
    assign almost_full = (wlevel >= AfullTh);
    assign full        = full_q;
    assign overflow    = overflow_q;

    // ---------------- read domain ----------------
    assign wgray_s = wsync_q[SYNC_STG-1];

    always_comb begin
        ren         = rd & ~empty_q;
        rptr_d      = ren ? rptr_q + PtrOne : rptr_q;
        rgray_d     = bin2gray(rptr_d);
        empty_d     = (rgray_d == wgray_s);
        underflow_d = underflow_q | (rd & empty_q);
    end

    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            rptr_q      <= '0;
            rgray_q     <= '0;
            empty_q     <= 1'b1;
            underflow_q <= 1'b0;
            for (int i = 0; i < int'(SYNC_STG); i++) wsync_q[i] <= '0;
        end else begin
            rptr_q      <= rptr_d;
            rgray_q     <= rgray_d;
            empty_q     <= empty_d;
            underflow_q <= underflow_d;
            wsync_q[0]  <= wgray_q;
            for (int i = 1; i < int'(SYNC_STG); i++) wsync_q[i] <= wsync_q[i-1];
        end
    end

    assign q            = mem_q[rptr_q[AW-1:0]];
    assign rlevel       = gray2bin(wgray_s) - rptr_q;
    assign almost_empty = (rlevel <= AemptyTh);
    assign empty        = empty_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_sd_async_fifo.sv
// Bench for sd_async_fifo: table-driven fill/drain, reset/latency sequences, randomized traffic
// against a queue model, and a narrow-parameter instance.
`timescale 1ns/1ps
module tb_sd_async_fifo;

    logic       wclk, rclk, rst;
    logic [3:0] d, q;
    logic       wr, rd;
    logic       full, almost_full, overflow, empty, almost_empty, underflow;
    logic [6:0] wlevel, rlevel;

    logic [7:0] p_d, p_q;
    logic       p_wr, p_rd;
    logic       p_full, p_afull, p_ovf, p_empty, p_aempty, p_udf;
    logic [4:0] p_wlevel, p_rlevel;

    int         n_cmp = 0;
    int         n_fail = 0;
    realtime    rhalf = 20.0;
    logic [3:0] model [$];

    typedef struct {
        int   n;
        int   level;
        logic aflag;
        logic flag;
    } vec_t;
    vec_t fill_v [5];
    vec_t drain_v [5];

    sd_async_fifo u_dut (
        .wclk(wclk), .rst(rst), .rclk(rclk), .d(d), .wr(wr), .full(full),
        .almost_full(almost_full), .wlevel(wlevel), .overflow(overflow), .q(q), .rd(rd),
        .empty(empty), .almost_empty(almost_empty), .rlevel(rlevel), .underflow(underflow)
    );

    sd_async_fifo #(.DW(8), .AW(4), .AFULL_TH(14)) u_p (
        .wclk(wclk), .rst(rst), .rclk(rclk), .d(p_d), .wr(p_wr), .full(p_full),
        .almost_full(p_afull), .wlevel(p_wlevel), .overflow(p_ovf), .q(p_q), .rd(p_rd),
        .empty(p_empty), .almost_empty(p_aempty), .rlevel(p_rlevel), .underflow(p_udf)
    );

    initial begin
        wclk = 1'b0;
        forever #10 wclk = ~wclk;
    end

    initial begin
        rclk = 1'b0;
        forever #(rhalf) rclk = ~rclk;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_empty"}, 32'(empty), 1);
        chk({tag, "_aempty"}, 32'(almost_empty), 1);
        chk({tag, "_full"}, 32'(full), 0);
        chk({tag, "_afull"}, 32'(almost_full), 0);
        chk({tag, "_wlevel"}, 32'(wlevel), 0);
        chk({tag, "_rlevel"}, 32'(rlevel), 0);
        chk({tag, "_overflow"}, 32'(overflow), 0);
        chk({tag, "_underflow"}, 32'(underflow), 0);
    endtask

    task automatic do_write(input logic [3:0] v);
        d  = v;
        wr = 1'b1;
        @(posedge wclk);
        #1 wr = 1'b0;
    endtask

    task automatic do_read();
        rd = 1'b1;
        @(posedge rclk);
        #1 rd = 1'b0;
    endtask

    initial begin
        int nw, nr, cnt, sent, recvd;
        fill_v[0]  = '{1, 1, 1'b0, 1'b0};
        fill_v[1]  = '{59, 59, 1'b0, 1'b0};
        fill_v[2]  = '{60, 60, 1'b1, 1'b0};
        fill_v[3]  = '{63, 63, 1'b1, 1'b0};
        fill_v[4]  = '{64, 64, 1'b1, 1'b1};
        drain_v[0] = '{1, 63, 1'b0, 1'b0};
        drain_v[1] = '{59, 5, 1'b0, 1'b0};
        drain_v[2] = '{60, 4, 1'b1, 1'b0};
        drain_v[3] = '{63, 1, 1'b1, 1'b0};
        drain_v[4] = '{64, 0, 1'b1, 1'b1};

        rst = 1'b1; wr = 1'b0; rd = 1'b0; d = '0;
        p_wr = 1'b0; p_rd = 1'b0; p_d = '0;
        #5 check_reset("reset");
        #30 rst = 1'b0;
        @(posedge wclk); #1;

        // Fill 64 words with no reads
        nw = 0;
        for (int v = 0; v < 5; v++) begin
            while (nw < fill_v[v].n) begin
                do_write(4'(nw));
                nw++;
            end
            chk("fill_wlevel", 32'(wlevel), fill_v[v].level);
            chk("fill_afull", 32'(almost_full), 32'(fill_v[v].aflag));
            chk("fill_full", 32'(full), 32'(fill_v[v].flag));
        end
        do_write(4'hA);
        chk("overflow_set", 32'(overflow), 1);
        chk("overflow_wlevel", 32'(wlevel), 64);
        chk("overflow_full", 32'(full), 1);

        repeat (4) @(posedge rclk);
        #1;
        chk("pre_drain_rlevel", 32'(rlevel), 64);
        chk("pre_drain_empty", 32'(empty), 0);
        chk("pre_drain_aempty", 32'(almost_empty), 0);

        // Drain all 64 and check order
        nr = 0;
        for (int v = 0; v < 5; v++) begin
            while (nr < drain_v[v].n) begin
                chk("drain_q", 32'(q), 32'(nr % 16));
                do_read();
                nr++;
            end
            chk("drain_rlevel", 32'(rlevel), drain_v[v].level);
            chk("drain_aempty", 32'(almost_empty), 32'(drain_v[v].aflag));
            chk("drain_empty", 32'(empty), 32'(drain_v[v].flag));
        end
        do_read();
        chk("underflow_set", 32'(underflow), 1);
        chk("underflow_rlevel", 32'(rlevel), 0);
        chk("overflow_sticky", 32'(overflow), 1);

        // Asynchronous reset while a write stream is running
        @(posedge wclk); #1;
        d = 4'h3; wr = 1'b1;
        @(posedge wclk);
        @(posedge wclk);
        #3 rst = 1'b1;
        #1 check_reset("midreset");
        wr = 1'b0;
        @(negedge wclk);
        #5 rst = 1'b0;
        @(posedge wclk); #1;

        // Single write into empty FIFO: empty falls on third rclk edge
        do_write(4'h7);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge rclk);
            #1 cnt++;
            if (!empty) break;
        end
        chk("latency_edges", 32'(cnt), 3);
        chk("latency_q", 32'(q), 7);
        chk("latency_rlevel", 32'(rlevel), 1);
        do_read();
        chk("latency_empty_after", 32'(empty), 1);

        // Random traffic, rclk 3x faster then 3x slower
        rhalf = 10.0 / 3.0;
        sent = 0;
        recvd = 0;
        @(posedge wclk); #1;
        fork
            begin
                for (int c = 0; c < 20000 && sent < 1000; c++) begin
                    if (sent >= 500) rhalf = 30.0;
                    d  = 4'($urandom);
                    wr = ($urandom_range(3) != 0);
                    if (wr && !full) begin
                        model.push_back(d);
                        sent++;
                    end
                    @(posedge wclk); #1;
                end
                wr = 1'b0;
            end
            begin
                logic [3:0] exp_q;
                @(posedge rclk); #1;
                for (int c = 0; c < 30000 && recvd < 1000; c++) begin
                    rd = ($urandom_range(3) != 0);
                    chk("wrap_rlevel_bound", 32'(int'(rlevel) <= model.size()), 1);
                    if (rd && !empty) begin
                        chk("wrap_nonempty", 32'(model.size() != 0), 1);
                        if (model.size() != 0) begin
                            exp_q = model.pop_front();
                            chk("wrap_q", 32'(q), 32'(exp_q));
                        end
                        recvd++;
                    end
                    @(posedge rclk); #1;
                end
                rd = 1'b0;
            end
        join
        chk("wrap_sent", 32'(sent), 1000);
        chk("wrap_recvd", 32'(recvd), 1000);
        chk("wrap_model_left", 32'(model.size()), 0);
        repeat (6) @(posedge rclk);
        @(posedge wclk); #1;
        chk("wrap_end_empty", 32'(empty), 1);
        chk("wrap_end_rlevel", 32'(rlevel), 0);
        chk("wrap_end_wlevel", 32'(wlevel), 0);
        chk("wrap_end_full", 32'(full), 0);

        // Narrow instance: DW=8, AW=4, AFULL_TH=14
        for (int i = 1; i <= 16; i++) begin
            p_d = 8'(i * 17);
            p_wr = 1'b1;
            @(posedge wclk);
            #1 p_wr = 1'b0;
            chk("param_wlevel", 32'(p_wlevel), 32'(i));
            chk("param_afull", 32'(p_afull), 32'(i >= 14));
            chk("param_full", 32'(p_full), 32'(i == 16));
        end
        p_wr = 1'b1;
        @(posedge wclk);
        #1 p_wr = 1'b0;
        chk("param_overflow", 32'(p_ovf), 1);
        chk("param_wlevel_hold", 32'(p_wlevel), 16);
        repeat (4) @(posedge rclk);
        #1;
        chk("param_q_head", 32'(p_q), 17);
        chk("param_rlevel", 32'(p_rlevel), 16);
        chk("param_empty", 32'(p_empty), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
